// File: rtl/processor_pkg.sv
// Shared defaults, FSM encoding and the signed clamp helper for the gain/average stage.
package processor_pkg;
   localparam int               DEF_DATA_W     = 10;
   localparam logic [9:0]       DEF_ADC_OFFSET = 10'h181;
   localparam logic [9:0]       DEF_DAC_OFFSET = 10'h200;
   localparam int               DEF_GAIN_W     = 8;
   localparam int               DEF_GAIN_FRAC  = 4;
   localparam int               DEF_LOG2_DEPTH = 3;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Clamp v into the signed range of a w-bit word.
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction
endpackage

// File: rtl/sample_ring.sv
// Circular sample buffer: returns the oldest entry and overwrites it in the same cycle.
module sample_ring #(
   parameter int DATA_W     = 10,
   parameter int LOG2_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  clr,
   input  logic [DATA_W-1:0]     din,
   output logic [DATA_W-1:0]     oldest,
   output logic [LOG2_DEPTH-1:0] wr_ptr
);
   logic [DATA_W-1:0] mem [1 << LOG2_DEPTH];

   assign oldest = mem[wr_ptr];

   // Contents are not reset; the CLEAR sweep zeroes them after every reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (clr || wr_en) begin
         mem[wr_ptr] <= clr ? '0 : din;
         wr_ptr      <= wr_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/processor_gain_avg.sv
// ADC->DAC stage: offset removal, optional moving average, fixed-point gain, saturation.
module processor_gain_avg
   import processor_pkg::*;
#(
   parameter int               DATA_W     = DEF_DATA_W,
   parameter logic [DATA_W-1:0] ADC_OFFSET = DEF_ADC_OFFSET,
   parameter logic [DATA_W-1:0] DAC_OFFSET = DEF_DAC_OFFSET,
   parameter int               GAIN_W     = DEF_GAIN_W,
   parameter int               GAIN_FRAC  = DEF_GAIN_FRAC,
   parameter int               LOG2_DEPTH = DEF_LOG2_DEPTH
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [GAIN_W-1:0] gain,
   input  logic              avg_en,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              sat_flag,
   output logic              drop_err
);
   localparam int DEPTH  = 1 << LOG2_DEPTH;
   localparam int SUM_W  = DATA_W + LOG2_DEPTH;
   localparam int P_W    = DATA_W + GAIN_W + 1;
   localparam int STAGES = 3;

   state_t                   state;
   logic                     accept;
   logic                     clr;
   logic [LOG2_DEPTH-1:0]    wr_ptr;
   logic signed [DATA_W-1:0] x;
   logic signed [DATA_W-1:0] x1;
   logic signed [DATA_W-1:0] oldest_s;
   logic signed [SUM_W-1:0]  sum;
   logic signed [DATA_W-1:0] a_avg;
   logic signed [DATA_W-1:0] a;
   logic signed [P_W-1:0]    p;
   logic signed [P_W-1:0]    s;
   logic signed [31:0]       s32;
   logic signed [31:0]       sat_val;
   logic [DATA_W-1:0]        c_val;
   logic                     c_clip;
   logic [STAGES:0]          vld_pipe;

   assign accept   = in_valid && in_ready;
   assign clr      = (state == ST_CLEAR);
   assign x        = data_in - ADC_OFFSET;
   assign a_avg    = DATA_W'(sum >>> LOG2_DEPTH);
   assign a        = avg_en ? a_avg : x1;
   assign s        = p >>> GAIN_FRAC;
   assign s32      = 32'(s);
   assign sat_val  = sat_signed(s32, DATA_W);
   assign out_valid = vld_pipe[STAGES];

   sample_ring #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring (
      .clk    (sysclk),
      .rst_n  (rst_n),
      .wr_en  (accept),
      .clr    (clr),
      .din    (x),
      .oldest (oldest_s),
      .wr_ptr (wr_ptr)
   );

   // CLEAR lasts one full sweep of the ring; wr_ptr wraps back to 0 on exit.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state    <= ST_CLEAR;
         in_ready <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: if (wr_ptr == LOG2_DEPTH'(DEPTH - 1)) begin
               state    <= ST_RUN;
               in_ready <= 1'b1;
            end
            default: in_ready <= 1'b1;
         endcase
         if (in_valid && !in_ready) drop_err <= 1'b1;
      end
   end

   // Accept -> multiply -> clamp -> output register, so out_valid lands 3 cycles after accept.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         sum      <= '0;
         x1       <= '0;
         p        <= '0;
         c_val    <= '0;
         c_clip   <= 1'b0;
         data_out <= DAC_OFFSET;
         sat_flag <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], accept};
         if (accept) begin
            x1  <= x;
            sum <= sum + SUM_W'(x) - SUM_W'(oldest_s);
         end
         if (vld_pipe[0]) p <= P_W'(a) * P_W'($signed({1'b0, gain}));
         if (vld_pipe[1]) begin
            c_val  <= DATA_W'(sat_val);
            c_clip <= (sat_val != s32);
         end
         if (vld_pipe[2]) begin
            data_out <= c_val + DAC_OFFSET;
            sat_flag <= c_clip;
         end
      end
   end
endmodule

// File: tb/tb_processor_gain_avg.sv
// Self-checking bench: vector table, directed corner sequences and a random run against a window model.
module tb_processor_gain_avg;
   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       avg_en = 1'b0;
   logic [9:0] data_in = '0;
   logic [7:0] gain = '0;
   logic       in_ready, out_valid, sat_flag, drop_err;
   logic [9:0] data_out;

   processor_gain_avg dut (
      .sysclk(sysclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .gain(gain), .avg_en(avg_en), .data_out(data_out),
      .out_valid(out_valid), .sat_flag(sat_flag), .drop_err(drop_err)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {int due; int x; int avg; logic [9:0] val; logic sat;} item_t;
   typedef struct {logic [9:0] din; logic [7:0] gain; logic [9:0] exp_out; logic exp_sat;} vec_t;

   item_t      q[$];
   int         win[$];
   int         cyc = 0, rcnt = 0;
   logic       drop_m = 1'b0;
   logic [9:0] last_out = 10'h200;
   logic       last_sat = 1'b0;
   int         n_tot = 0, n_pass = 0;

   function automatic int floordiv(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      else n_pass++;
   endtask

   // One clock: update the model for the coming edge, clock, then compare every output.
   task automatic step();
      int    e_n, xv, sm, av, pr, sv;
      item_t it;
      logic  exp_v;
      e_n = cyc + 1;
      if (!rst_n) begin
         q.delete(); win.delete();
         for (int i = 0; i < 8; i++) win.push_back(0);
         rcnt = 0; drop_m = 1'b0; last_out = 10'h200; last_sat = 1'b0;
      end else begin
         foreach (q[i]) if (q[i].due - 2 == e_n) begin
            av = avg_en ? q[i].avg : q[i].x;
            pr = av * int'(gain);
            sv = floordiv(pr, 16);
            q[i].sat = (sv > 511) || (sv < -512);
            if (sv > 511) sv = 511;
            if (sv < -512) sv = -512;
            q[i].val = 10'(sv + 512);
         end
         if (in_valid) begin
            if (rcnt >= 8) begin
               xv = (int'(data_in) - 385 + 1024) % 1024;
               if (xv >= 512) xv -= 1024;
               win.push_back(xv);
               void'(win.pop_front());
               sm = win.sum();
               it.x = xv; it.avg = floordiv(sm, 8); it.due = e_n + 3;
               it.val = '0; it.sat = 1'b0;
               q.push_back(it);
            end else drop_m = 1'b1;
         end
         if (rcnt < 8) rcnt++;
      end
      @(posedge sysclk); #1;
      cyc++;
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         exp_v = 1'b1; last_out = q[0].val; last_sat = q[0].sat;
         void'(q.pop_front());
      end
      chk("out_valid", out_valid, exp_v);
      chk("data_out", data_out, last_out);
      chk("sat_flag", sat_flag, last_sat);
      chk("in_ready", in_ready, rcnt >= 8);
      chk("drop_err", drop_err, drop_m);
   endtask

   vec_t       tv[10];
   logic [9:0] exp4[10];
   logic [9:0] got[$];
   int         nv;

   initial begin
      tv[0] = '{10'h191, 8'h40, 10'h240, 1'b0};
      tv[1] = '{10'h281, 8'h40, 10'h3FF, 1'b1};
      tv[2] = '{10'h081, 8'h40, 10'h000, 1'b1};
      tv[3] = '{10'h181, 8'h10, 10'h200, 1'b0};
      tv[4] = '{10'h180, 8'h10, 10'h1FF, 1'b0};
      tv[5] = '{10'h1A1, 8'h18, 10'h230, 1'b0};
      tv[6] = '{10'h17E, 8'h18, 10'h1FB, 1'b0};
      tv[7] = '{10'h000, 8'h10, 10'h07F, 1'b0};
      tv[8] = '{10'h3FF, 8'h10, 10'h07E, 1'b0};
      tv[9] = '{10'h191, 8'hFF, 10'h2FF, 1'b0};
      for (int i = 0; i < 10; i++) exp4[i] = (i < 8) ? 10'(10'h201 + i) : 10'h208;

      // Reset, then CLEAR with a sample offered in the middle of it.
      rst_n = 1'b0; step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i == 3);
         data_in = 10'h191;
         step();
         chk("clear_in_ready", in_ready, (i == 7));
         chk("clear_out_valid", out_valid, 1'b0);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("drop_sticky", drop_err, 1'b1);

      // Isolated bypass samples from the vector table.
      avg_en = 1'b0;
      foreach (tv[i]) begin
         data_in = tv[i].din; gain = tv[i].gain; in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         step(); step();
         chk("tbl_early", out_valid, 1'b0);
         step();
         chk("tbl_valid", out_valid, 1'b1);
         chk("tbl_data", data_out, tv[i].exp_out);
         chk("tbl_sat", sat_flag, tv[i].exp_sat);
      end

      // Fresh clear, then averaging warm-up ramp with back-to-back samples.
      rst_n = 1'b0; step();
      chk("rst_drop_clr", drop_err, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      avg_en = 1'b1; gain = 8'h10; data_in = 10'h189;
      got.delete();
      for (int i = 0; i < 15; i++) begin
         in_valid = (i < 10);
         step();
         if (out_valid) got.push_back(data_out);
      end
      chk("ramp_count", got.size(), 10);
      nv = (got.size() < 10) ? got.size() : 10;
      for (int i = 0; i < nv; i++) chk("ramp_data", got[i], exp4[i]);

      // Three accepts then reset: nothing may come out, CLEAR runs again.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; data_in = 10'(10'h1C0 + i); step();
      end
      in_valid = 1'b0; rst_n = 1'b0; step();
      rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) nv++;
         if (i < 7) chk("reclear_ready", in_ready, 1'b0);
      end
      chk("reset_flush", nv, 0);
      chk("reset_out", data_out, 10'h200);
      chk("reclear_done", in_ready, 1'b1);

      // Random traffic with live gain/avg_en changes.
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         data_in  = 10'($urandom_range(0, 1023));
         avg_en   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) gain = 8'($urandom_range(0, 255));
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
